// File: rtl/mmio_pkg.sv
// Shared register offsets, CTRL bit positions and the default window base for mmio_responder.
package mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

    localparam logic [7:0] OFF_PORT_OUT = 8'h00;
    localparam logic [7:0] OFF_PORT_IN  = 8'h04;
    localparam logic [7:0] OFF_EDGE     = 8'h08;
    localparam logic [7:0] OFF_CTRL     = 8'h0C;
    localparam logic [7:0] OFF_COUNT    = 8'h10;
    localparam logic [7:0] OFF_CMP      = 8'h14;
    localparam logic [7:0] OFF_STATUS   = 8'h18;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_W      = 3;

endpackage

// File: rtl/input_sync_edge.sv
// Two-flop synchronizer for external inputs with sticky rising-edge flags (write-1-to-clear).
module input_sync_edge #(
    parameter int unsigned IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] port_i,
    input  logic [IN_WIDTH-1:0] w1c_i,
    output logic [IN_WIDTH-1:0] sync_o,
    output logic [IN_WIDTH-1:0] edge_o
);

    logic [IN_WIDTH-1:0] s1_q;
    logic [IN_WIDTH-1:0] sync_q;
    logic [IN_WIDTH-1:0] edge_q, edge_d;

    // A new edge in the same cycle as a clear keeps the flag set.
    always_comb begin
        edge_d = (edge_q & ~w1c_i) | (s1_q & ~sync_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            sync_q <= '0;
            edge_q <= '0;
        end else begin
            s1_q   <= port_i;
            sync_q <= s1_q;
            edge_q <= edge_d;
        end
    end

    assign sync_o = sync_q;
    assign edge_o = edge_q;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder: output port, synchronized input port with edge flags,
// and a compare/match timer with interrupt, all in a 256-byte window on the data bus.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         ReadData,
    output logic                Hit,
    output logic [31:0]         PortOut,
    output logic                Irq
);

    logic [31:0]         port_out_q, port_out_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [31:0]         count_q, count_d;
    logic [31:0]         cmp_q, cmp_d;
    logic                match_q, match_d;
    logic                irq_q, irq_d;
    logic                match_set;
    logic                wr_en;
    logic [7:0]          off;
    logic [IN_WIDTH-1:0] sync_val, edge_val, edge_w1c;
    logic [31:0]         rd_val;
    logic                unused_addr;

    assign Hit         = (Address[31:8] == BASE_ADDR[31:8]);
    assign wr_en       = Hit & MemWrite;
    assign off         = {Address[7:2], 2'b00};
    assign unused_addr = ^Address[1:0];

    assign edge_w1c = (wr_en && off == OFF_EDGE) ? WriteData[IN_WIDTH-1:0] : '0;

    input_sync_edge #(
        .IN_WIDTH(IN_WIDTH)
    ) u_input_sync_edge (
        .clk   (clk),
        .reset (reset),
        .port_i(PortIn),
        .w1c_i (edge_w1c),
        .sync_o(sync_val),
        .edge_o(edge_val)
    );

    always_comb begin
        port_out_d = port_out_q;
        ctrl_d     = ctrl_q;
        cmp_d      = cmp_q;
        if (wr_en) begin
            case (off)
                OFF_PORT_OUT: port_out_d = WriteData;
                OFF_CTRL:     ctrl_d     = WriteData[CTRL_W-1:0];
                OFF_CMP:      cmp_d      = WriteData;
                default:      ;
            endcase
        end
    end

    // A software COUNT store overrides the timer step for that cycle.
    always_comb begin
        count_d   = count_q;
        match_set = 1'b0;
        if (wr_en && off == OFF_COUNT) begin
            count_d = WriteData;
        end else if (ctrl_q[CTRL_EN]) begin
            count_d = count_q + 32'd1;
            if (count_q == cmp_q) begin
                match_set = 1'b1;
                if (ctrl_q[CTRL_RELOAD]) count_d = '0;
            end
        end
    end

    always_comb begin
        match_d = (match_q & ~(wr_en && off == OFF_STATUS && WriteData[0])) | match_set;
        irq_d   = match_q & ctrl_q[CTRL_IRQ_EN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out_q <= '0;
            ctrl_q     <= '0;
            count_q    <= '0;
            cmp_q      <= '0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_PORT_OUT: rd_val = port_out_q;
            OFF_PORT_IN:  rd_val[IN_WIDTH-1:0] = sync_val;
            OFF_EDGE:     rd_val[IN_WIDTH-1:0] = edge_val;
            OFF_CTRL:     rd_val[CTRL_W-1:0] = ctrl_q;
            OFF_COUNT:    rd_val = count_q;
            OFF_CMP:      rd_val = cmp_q;
            OFF_STATUS:   rd_val[0] = match_q;
            default:      rd_val = '0;
        endcase
    end

    assign ReadData = (Hit && MemRead) ? rd_val : '0;
    assign PortOut  = port_out_q;
    assign Irq      = irq_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: loads push expected data, a negedge monitor checks it.
module tb_mmio_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        Irq;

    mmio_responder #(
        .BASE_ADDR(BASE),
        .IN_WIDTH (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .PortIn   (PortIn),
        .ReadData (ReadData),
        .Hit      (Hit),
        .PortOut  (PortOut),
        .Irq      (Irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        hit;
        logic        ci;
        logic        irq;
        logic        cp;
        logic [31:0] pout;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every cycle with a load presented is one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (MemRead === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: got read at 0x%08h expected none", Address);
            end else begin
                e = sb.pop_front();
                chk({e.name, ".rdata"}, ReadData, e.rdata);
                chk({e.name, ".hit"}, {31'd0, Hit}, {31'd0, e.hit});
                if (e.ci) chk({e.name, ".irq"}, {31'd0, Irq}, {31'd0, e.irq});
                if (e.cp) chk({e.name, ".portout"}, PortOut, e.pout);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            Address  = 32'h0;
            MemWrite = 1'b0;
            MemRead  = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        Address   = BASE | {24'd0, off};
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic push(input string name, input logic [31:0] addr, input logic [31:0] exp,
                        input logic ci, input logic irq, input logic cp, input logic [31:0] pout);
        exp_t e;
        e.name  = name;
        e.rdata = exp;
        e.hit   = (addr[31:8] == BASE[31:8]);
        e.ci    = ci;
        e.irq   = irq;
        e.cp    = cp;
        e.pout  = pout;
        sb.push_back(e);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp,
                      input logic ci = 1'b0, input logic irq = 1'b0,
                      input logic cp = 1'b0, input logic [31:0] pout = 32'h0);
        Address  = addr;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        push(name, addr, exp, ci, irq, cp, pout);
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
    endtask

    task automatic rdwr(input string name, input logic [7:0] off, input logic [31:0] data,
                        input logic [31:0] exp);
        Address   = BASE | {24'd0, off};
        WriteData = data;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        push(name, Address, exp, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rd("rst_port_out", BASE | 32'h00, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
        reset = 1'b0;
        idle(1);

        // Store / load
        wr(8'h00, 32'hDEAD_BEEF);
        rd("port_out", BASE | 32'h00, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        rd("port_out_lowbits", BASE | 32'h03, 32'hDEAD_BEEF);
        rd("unmapped_1c", BASE | 32'h1C, 32'h0);
        rd("miss", 32'h1001_0000, 32'h0);
        wr(8'h1C, 32'h1234_5678);
        rd("unmapped_wr", BASE | 32'h1C, 32'h0);
        wr(8'h0C, 32'hFFFF_FFF8);
        rd("ctrl_mask", BASE | 32'h0C, 32'h0);
        rdwr("rdwr_prewrite", 8'h00, 32'h1234_5678, 32'hDEAD_BEEF);
        Address = 32'h1001_0000; WriteData = 32'h0; MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        rd("port_out_after", BASE | 32'h00, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h1234_5678);

        // Input synchronizer and edge flags
        PortIn = 8'h01;
        idle(1);
        rd("port_in_s1_only", BASE | 32'h04, 32'h0);
        rd("port_in_sync", BASE | 32'h04, 32'h1);
        rd("edge_set", BASE | 32'h08, 32'h1);
        wr(8'h08, 32'h1);
        rd("edge_cleared", BASE | 32'h08, 32'h0);
        PortIn = 8'h00;
        idle(3);
        PortIn = 8'h01;
        idle(1);
        wr(8'h08, 32'h1);
        rd("edge_set_wins", BASE | 32'h08, 32'h1);
        rd("edge_sticky", BASE | 32'h08, 32'h1);
        PortIn = 8'h00;

        // Mid-run asynchronous reset
        wr(8'h00, 32'h0000_00A5);
        wr(8'h10, 32'd5);
        wr(8'h14, 32'd5);
        wr(8'h0C, 32'h5);
        idle(1);
        rd("pre_rst_status", BASE | 32'h18, 32'h1, 1'b1, 1'b0);
        rd("pre_rst_port", BASE | 32'h00, 32'hA5, 1'b1, 1'b1, 1'b1, 32'hA5);
        reset = 1'b1;
        rd("rst_count", BASE | 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
        rd("rst_status", BASE | 32'h18, 32'h0);
        rd("rst_ctrl", BASE | 32'h0C, 32'h0);
        rd("rst_cmp", BASE | 32'h14, 32'h0);
        rd("rst_edge", BASE | 32'h08, 32'h0);
        rd("rst_port_in", BASE | 32'h04, 32'h0);
        reset = 1'b0;
        idle(1);

        // Auto-reload timer
        wr(8'h14, 32'd3);
        wr(8'h0C, 32'h7);
        rd("ar_c0", BASE | 32'h10, 32'd0);
        rd("ar_c1", BASE | 32'h10, 32'd1);
        rd("ar_c2", BASE | 32'h10, 32'd2);
        rd("ar_c3", BASE | 32'h10, 32'd3, 1'b1, 1'b0);
        rd("ar_c0b", BASE | 32'h10, 32'd0, 1'b1, 1'b0);
        rd("ar_c1b", BASE | 32'h10, 32'd1, 1'b1, 1'b1);
        rd("ar_status", BASE | 32'h18, 32'h1, 1'b1, 1'b1);
        wr(8'h0C, 32'h6);
        wr(8'h18, 32'h1);
        rd("ar_w1c", BASE | 32'h18, 32'h0, 1'b1, 1'b1);
        rd("ar_irq_drop", BASE | 32'h18, 32'h0, 1'b1, 1'b0);
        rd("ar_hold", BASE | 32'h10, 32'd0);

        // Wrap without reload, then a store while counting
        wr(8'h0C, 32'h0);
        wr(8'h10, 32'hFFFF_FFFE);
        wr(8'h14, 32'hFFFF_FFFF);
        wr(8'h0C, 32'h1);
        rd("wr_fe", BASE | 32'h10, 32'hFFFF_FFFE);
        rd("wr_ff", BASE | 32'h10, 32'hFFFF_FFFF);
        rd("wr_0", BASE | 32'h10, 32'h0, 1'b1, 1'b0);
        rd("wr_status", BASE | 32'h18, 32'h1, 1'b1, 1'b0);
        wr(8'h10, 32'h100);
        rd("ld_count", BASE | 32'h10, 32'h100, 1'b1, 1'b0);
        rd("ld_count_inc", BASE | 32'h10, 32'h101);

        idle(2);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the processor's data-memory bus (the EX/MEM-stage Address/WriteData/MemWrite/MemRead signals), answering loads and stores in a 256-byte window alongside the data RAM. It provides:
- a 32-bit output port
- a synchronized 8-bit input port with sticky rising-edge flags
- a 32-bit compare/match timer with an interrupt line

The top level uses `Hit` to select `ReadData` over RAM data ahead of the MEM/WB register.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_0000, window base; bits [7:0] must be zero.
- `IN_WIDTH`, 8, width of `PortIn`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `Address`  in  32  byte address from EX/MEM ALU result.
- `WriteData`  in  32  store data (rt).
- `MemWrite`  in  1  store strobe, sampled at posedge.
- `MemRead`  in  1  load strobe.
- `PortIn`  in  IN_WIDTH  asynchronous external inputs.
- `ReadData`  out  32  combinational load data.
- `Hit`  out  1  combinational; `Address[31:8] == BASE_ADDR[31:8]`.
- `PortOut`  out  32  registered output port.
- `Irq`  out  1  registered: `STATUS.match & CTRL.irq_en`.

## Operation
Register map, as byte offsets within the window. `Address[1:0]` is ignored (word access only).
- 0x00 `PORT_OUT`, RW, 32 bits; drives `PortOut`.
- 0x04 `PORT_IN`, RO; reads `{zeros, sync_q}`.
- 0x08 `EDGE`, RW1C, IN_WIDTH bits; sticky rising-edge flags.
- 0x0C `CTRL`, RW:
  - bit0 `en`
  - bit1 `reload`
  - bit2 `irq_en`
  - other bits read 0
- 0x10 `COUNT`, RW, 32 bits.
- 0x14 `CMP`, RW, 32 bits.
- 0x18 `STATUS`, RW1C; bit0 `match`.

Bus access:
- A write occurs at posedge when `Hit & MemWrite`.
- `ReadData` equals the addressed register whenever `Hit & MemRead`, and is 0 otherwise.
- Unmapped offsets: reads return 0; writes are ignored.
- `MemRead` and `MemWrite` asserted together: the write happens, and `ReadData` shows the pre-write value.

Input path:
- Two-flop synchronizer: `s1 <= PortIn`, `sync_q <= s1`.
- `EDGE[i]` sets when `s1[i] & ~sync_q[i]`.

Timer, evaluated each posedge, in priority order:
1. A software write to `COUNT` loads `WriteData`.
2. Otherwise, if `en`:
   - if `COUNT == CMP`: set `match`; `COUNT <= reload ? 0 : COUNT+1`.
   - else `COUNT <= COUNT+1`.
   - `COUNT+1` wraps modulo 2^32.
3. If `en` = 0, `COUNT` holds.

The match comparison uses the current (pre-update) `COUNT`.

Simultaneous events:
- A hardware set of `EDGE`/`match` and a software W1C in the same cycle: the set wins, and the flag stays 1.
- A write to `CMP` takes effect for the comparison on the following cycle.

## Timing
- Reset (async): `PortOut`=0, `Irq`=0, `s1`/`sync_q`=0, `EDGE`=0, `CTRL`=0, `COUNT`=0, `CMP`=0, `STATUS`=0. `ReadData` and `Hit` are combinational from inputs and state.
- Reset asserted mid-operation clears immediately, without waiting for a clock edge. A pending store is lost.
- Store latency: a register is updated at the posedge ending the MEM cycle. A load in the next cycle sees the new value.
- Load latency: 0 cycles; `ReadData` is valid in the same cycle as `MemRead`, before the MEM/WB capture edge.
- `PortIn` rising edge set up before posedge k:
  - `s1` = 1 at k.
  - `sync_q` = 1 and `EDGE` set at k+1.
  - `PORT_IN` reads 1 from k+1.
- `Irq` updates one posedge after `match`/`irq_en` change, and is level-held until `match` is cleared.

## Structure
- Package `mmio_pkg` holds:
  - offset localparams `OFF_PORT_OUT`..`OFF_STATUS`
  - `CTRL` bit indices `CTRL_EN`, `CTRL_RELOAD`, `CTRL_IRQ_EN`
  - default `BASE_ADDR`
- Sub-module `input_sync_edge` (parameter `IN_WIDTH`) contains the synchronizer plus sticky edge flags with a W1C port, including the set-wins rule.
- Top level contains the decode, register file, timer and read mux.

## Test plan
- Reset check: assert `reset` mid-run with `COUNT`=5 and `PortOut`=0xA5 → all registers read 0 and `Irq`=0 immediately after reset.
- Store/load: store 0xDEAD_BEEF to 0xFFFF_0000 → `PortOut`=0xDEAD_BEEF next cycle. Load from 0xFFFF_0000 returns it. Load from 0xFFFF_001C returns 0. Load from 0x1001_0000 gives `Hit`=0 and `ReadData`=0.
- Input edge: drive `PortIn`=0x01 → `PORT_IN`=0x01 and `EDGE`=0x01 two posedges later. W1C 0x01 clears it. A W1C coinciding with a new edge on bit0 leaves it at 1.
- Timer auto-reload: `CMP`=3, `CTRL`=0b111 → `COUNT` sequence 0,1,2,3,0,1. `STATUS.match` set after the 3→0 transition, and `Irq`=1 one cycle later. W1C `STATUS` drops `Irq` the following cycle.
- Timer wrap, no reload:
  - `COUNT`=0xFFFF_FFFE, `CMP`=0xFFFF_FFFF, `CTRL`=0b001 → `COUNT` goes FFFF_FFFF, then 0; `match` set; `Irq` stays 0.
  - A store to `COUNT` during counting loads the store value, not the increment.
